// File: rtl/eq_band_mixer_pkg.sv
// Shared equalizer definitions: mixer FSM encoding and default
// fixed-point formats for the band mixer.
package eq_band_mixer_pkg;

  localparam int MAGNITUD_DEF  = 8;
  localparam int DECIMAL_DEF   = 14;
  localparam int N_ADC_DEF     = 12;
  localparam int GAIN_W_DEF    = 8;
  localparam int GAIN_FRAC_DEF = 6;
  localparam int NUM_BANDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/saturador_dac.sv
// Clamps the wide accumulator to the signed N-bit range and keeps
// the top N_ADC bits as the DAC code.
module saturador_dac #(
  parameter int ACC_W = 34,
  parameter int N     = 23,
  parameter int N_ADC = 12
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [N_ADC-1:0] code,
  output logic                    sat
);

  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  logic [N-1:0] clamped;

  always_comb begin
    clamped = acc[N-1:0];
    sat     = 1'b0;
    if (acc > MAXV) begin
      clamped = {1'b0, {(N-1){1'b1}}};
      sat     = 1'b1;
    end else if (acc < MINV) begin
      clamped = {1'b1, {(N-1){1'b0}}};
      sat     = 1'b1;
    end
  end

  // Dropping the low bits floors toward negative infinity.
  assign code = clamped[N-1 -: N_ADC];

endmodule

// File: rtl/eq_band_mixer.sv
// Gain-weighted band mixer: one shared multiplier walks the bands,
// then the sum is saturated into a DAC code.
module eq_band_mixer
  import eq_band_mixer_pkg::*;
#(
  parameter int Magnitud  = MAGNITUD_DEF,
  parameter int Decimal   = DECIMAL_DEF,
  parameter int N         = Magnitud + Decimal + 1,
  parameter int N_ADC     = N_ADC_DEF,
  parameter int NUM_BANDS = NUM_BANDS_DEF,
  parameter int GAIN_W    = GAIN_W_DEF,
  parameter int GAIN_FRAC = GAIN_FRAC_DEF
) (
  input  logic                        clock_In,
  input  logic                        Reset,
  input  logic                        sample_valid,
  input  logic [NUM_BANDS*N-1:0]      band_data,
  input  logic [NUM_BANDS*GAIN_W-1:0] band_gain,
  input  logic [NUM_BANDS-1:0]        band_mask,
  output logic                        busy,
  output logic                        out_valid,
  output logic [N_ADC-1:0]            Dac,
  output logic                        sat_flag,
  output logic                        overrun
);

  localparam int P  = N + GAIN_W + 1;
  localparam int A  = P + $clog2(NUM_BANDS);
  localparam int IW = idx_w(NUM_BANDS);

  state_t                      state;
  logic [IW-1:0]               idx;
  logic [NUM_BANDS*N-1:0]      data_q;
  logic [NUM_BANDS*GAIN_W-1:0] gain_q;
  logic [NUM_BANDS-1:0]        mask_q;
  logic signed [A-1:0]         acc_q;

  logic signed [N-1:0]   cur_d;
  logic [GAIN_W-1:0]     cur_g;
  logic signed [P-1:0]   prod;
  logic signed [P-1:0]   shifted;
  logic signed [A-1:0]   addend;
  logic [N_ADC-1:0]      code;
  logic                  sat;

  assign cur_d   = data_q[idx*N +: N];
  assign cur_g   = gain_q[idx*GAIN_W +: GAIN_W];
  // Gain is zero-extended so it is always a non-negative factor.
  assign prod    = P'(cur_d) * $signed(P'(cur_g));
  assign shifted = prod >>> GAIN_FRAC;
  assign addend  = mask_q[idx] ? A'(shifted) : '0;

  saturador_dac #(
    .ACC_W (A),
    .N     (N),
    .N_ADC (N_ADC)
  ) u_sat (
    .acc  (acc_q),
    .code (code),
    .sat  (sat)
  );

  always_ff @(posedge clock_In) begin
    if (Reset) begin
      state     <= IDLE;
      idx       <= '0;
      acc_q     <= '0;
      data_q    <= '0;
      gain_q    <= '0;
      mask_q    <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      Dac       <= '0;
      sat_flag  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sample_valid && state != IDLE)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (sample_valid) begin
            data_q <= band_data;
            gain_q <= band_gain;
            mask_q <= band_mask;
            acc_q  <= '0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_q + addend;
          if (idx == IW'(NUM_BANDS-1))
            state <= SAT;
          else
            idx <= idx + IW'(1);
        end
        SAT: begin
          Dac       <= code;
          sat_flag  <= sat;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Self-checking bench for eq_band_mixer: vector table with a
// scoreboard queue plus directed overrun and reset sequences.
module tb_eq_band_mixer;

  localparam int N  = 23;
  localparam int NB = 4;
  localparam int GW = 8;
  localparam int NA = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sv  = 1'b0;
  logic [NB*N-1:0]  bd = '0;
  logic [NB*GW-1:0] bg = '0;
  logic [NB-1:0]    bm = '0;
  logic busy, ov, sat, ovr;
  logic [NA-1:0] dac;

  typedef struct {
    logic signed [N-1:0] d[NB];
    logic [GW-1:0]       g[NB];
    logic [NB-1:0]       m;
    logic [NA-1:0]       dac;
    logic                sat;
  } vec_t;

  typedef struct {
    logic [NA-1:0] dac;
    logic          sat;
  } exp_t;

  exp_t sb[$];
  vec_t vt[8];
  int pass_n = 0;
  int tot_n  = 0;

  eq_band_mixer dut (
    .clock_In     (clk),
    .Reset        (rst),
    .sample_valid (sv),
    .band_data    (bd),
    .band_gain    (bg),
    .band_mask    (bm),
    .busy         (busy),
    .out_valid    (ov),
    .Dac          (dac),
    .sat_flag     (sat),
    .overrun      (ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic exp_t model(input vec_t v);
    exp_t   e;
    longint acc;
    acc = 0;
    for (int k = 0; k < NB; k++)
      if (v.m[k])
        acc += (longint'(v.d[k]) * longint'(v.g[k])) >>> 6;
    e.sat = 1'b0;
    if (acc > 64'sd4194303) begin
      acc = 4194303; e.sat = 1'b1;
    end else if (acc < -64'sd4194304) begin
      acc = -4194304; e.sat = 1'b1;
    end
    acc = acc >>> 11;
    e.dac = NA'(acc);
    return e;
  endfunction

  task automatic drive(input vec_t v);
    for (int k = 0; k < NB; k++) begin
      bd[k*N +: N]   = v.d[k];
      bg[k*GW +: GW] = v.g[k];
    end
    bm = v.m;
    sv = 1'b1;
  endtask

  task automatic scramble();
    for (int k = 0; k < NB; k++) bd[k*N +: N] = N'($urandom);
    bg = $urandom;
    bm = NB'($urandom);
  endtask

  task automatic run_mix(input vec_t v, input string nm);
    exp_t e;
    int   cyc;
    bit   seen;
    e.dac = v.dac;
    e.sat = v.sat;
    sb.push_back(e);
    drive(v);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 20 && !seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        sv = 1'b0;
        scramble();
      end
      if (ov) seen = 1'b1;
    end
    chk({nm, "_latency"}, cyc, 6);
    e = sb.pop_front();
    chk({nm, "_dac"}, 32'(dac), 32'(e.dac));
    chk({nm, "_sat"}, 32'(sat), 32'(e.sat));
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(ov), 0);
    chk({nm, "_idle"}, 32'(busy), 0);
    chk({nm, "_hold"}, 32'(dac), 32'(e.dac));
  endtask

  initial begin
    exp_t e;
    int   cnt, first;

    for (int k = 0; k < NB; k++) begin
      vt[0].d[k] = 23'sd16384;   vt[0].g[k] = 8'd64;
      vt[2].d[k] = 23'sd4194303; vt[2].g[k] = 8'd128;
      vt[3].d[k] = N'($urandom); vt[3].g[k] = 8'd200;
      vt[4].d[k] = -23'sd4194304; vt[4].g[k] = 8'd255;
      vt[1].g[k] = 8'd64;
    end
    vt[0].m = 4'hF; vt[0].dac = 12'd32;  vt[0].sat = 1'b0;
    vt[1].d[0] = -23'sd16384; vt[1].d[1] = 23'sd123456;
    vt[1].d[2] = -23'sd77777; vt[1].d[3] = 23'sd999;
    vt[1].m = 4'h1; vt[1].dac = 12'hFF8; vt[1].sat = 1'b0;
    vt[2].m = 4'hF; vt[2].dac = 12'h7FF; vt[2].sat = 1'b1;
    vt[3].m = 4'h0; vt[3].dac = 12'h000; vt[3].sat = 1'b0;
    vt[4].m = 4'hF; vt[4].dac = 12'h800; vt[4].sat = 1'b1;
    for (int i = 5; i < 8; i++) begin
      for (int k = 0; k < NB; k++) begin
        vt[i].d[k] = N'($urandom);
        vt[i].g[k] = GW'($urandom);
      end
      vt[i].m = NB'($urandom);
      e = model(vt[i]);
      vt[i].dac = e.dac;
      vt[i].sat = e.sat;
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(ov), 0);
    chk("rst_dac", 32'(dac), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_overrun", 32'(ovr), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_mix(vt[i], $sformatf("vec%0d", i));
    chk("no_overrun", 32'(ovr), 0);

    // Second sample two cycles into a mix must be dropped.
    e.dac = vt[0].dac;
    e.sat = vt[0].sat;
    sb.push_back(e);
    drive(vt[0]);
    cnt   = 0;
    first = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) sv = 1'b0;
      if (c == 2) drive(vt[2]);
      if (c == 3) begin
        sv = 1'b0;
        chk("ovr_set", 32'(ovr), 1);
      end
      if (ov) begin
        cnt++;
        if (first == 0) begin
          first = c;
          e = sb.pop_front();
          chk("ovr_dac", 32'(dac), 32'(e.dac));
          chk("ovr_sat", 32'(sat), 32'(e.sat));
        end
      end
    end
    sb.delete();
    chk("ovr_count", cnt, 1);
    chk("ovr_first", first, 6);
    chk("ovr_sticky", 32'(ovr), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ovr_clear", 32'(ovr), 0);

    run_mix(vt[2], "pre_abort");

    // Reset mid-mix aborts, then a fresh capture at cycle 5.
    drive(vt[4]);
    cnt   = 0;
    first = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) sv = 1'b0;
      if (c == 3) rst = 1'b1;
      if (c == 4) begin
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_dac", 32'(dac), 0);
        chk("abort_sat", 32'(sat), 0);
      end
      if (c == 5) begin
        e.dac = vt[0].dac;
        e.sat = vt[0].sat;
        sb.push_back(e);
        drive(vt[0]);
      end
      if (c == 6) sv = 1'b0;
      if (ov) begin
        cnt++;
        if (first == 0) begin
          first = c;
          e = sb.pop_front();
          chk("abort_new_dac", 32'(dac), 32'(e.dac));
        end
      end
    end
    sb.delete();
    chk("abort_count", cnt, 1);
    chk("abort_first", first, 11);

    // Reset wins over a simultaneous sample_valid.
    drive(vt[0]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sv  = 1'b0;
    chk("prio_busy", 32'(busy), 0);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ov || busy) cnt++;
    end
    chk("prio_quiet", cnt, 0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule

// File: doc/eq_band_mixer.md
EQ_BAND_MIXER -- requirements
Module: eq_band_mixer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- Magnitud, 8, integer bits of the band samples.
- Decimal, 14, fraction bits of the band samples.
- N, Magnitud+Decimal+1, signed band-sample width.
- N_ADC, 12, DAC code width.
- NUM_BANDS, 4, band count, at least 1.
- GAIN_W, 8, unsigned gain width.
- GAIN_FRAC, 6, gain fraction bits, so 64 = 1.0.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock_In, in, 1, the single clock.
- Reset, in, 1, synchronous, active-high.
- sample_valid, in, 1, a new band set is present.
- band_data, in, NUM_BANDS*N, signed band outputs; band k is at [k*N +: N].
- band_gain, in, NUM_BANDS*GAIN_W, unsigned gains; band k is at [k*GAIN_W +: GAIN_W].
- band_mask, in, NUM_BANDS, band-enable mask.
- busy, out, 1, a mix is in progress.
- out_valid, out, 1, one-cycle pulse when Dac is updated.
- Dac, out, N_ADC, signed two's-complement DAC code.
- sat_flag, out, 1, the current Dac value was clamped.
- overrun, out, 1, sticky flag: a sample was dropped.

Function
REQ-003 The FSM SHALL have four states: IDLE, ACCUM, SAT, OUT.
REQ-004 In IDLE, sample_valid=1 SHALL capture band_data, band_gain and band_mask into registers, clear the accumulator and index, and go to ACCUM.
REQ-005 In ACCUM, on each cycle for idx = 0..NUM_BANDS-1, the accumulator SHALL add (data[idx]*gain[idx]) >>> GAIN_FRAC when mask[idx]=1, and add 0 otherwise.
REQ-006 There SHALL be exactly one multiplier, time-multiplexed over the bands.
REQ-007 The product SHALL be N+GAIN_W+1 bits, with the gain zero-extended; the shift SHALL be arithmetic.
REQ-008 The accumulator SHALL be N+GAIN_W+1+clog2(NUM_BANDS) bits and SHALL never overflow.
REQ-009 After the last band, ACCUM SHALL go to SAT.
REQ-010 SAT SHALL clamp the accumulator to the signed N-bit range [-2^(N-1), 2^(N-1)-1] and set an internal sat bit if clamping occurred.
REQ-011 SAT SHALL form the code as saturated[N-1 -: N_ADC], i.e. truncation toward negative infinity.
REQ-012 In OUT, Dac, sat_flag and out_valid=1 SHALL be registered for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-013 Latency: with sample_valid at cycle 0, out_valid SHALL be high at cycle NUM_BANDS+2.
REQ-014 Dac and sat_flag SHALL hold their values until the next out_valid.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 sample_valid while busy=1 SHALL be ignored and SHALL set overrun to 1; overrun is cleared only by Reset.
REQ-017 sample_valid in the same cycle as OUT SHALL count as an overrun; a new capture is accepted only in IDLE.
REQ-018 A capture with band_mask = 0 SHALL still produce out_valid, with Dac=0 and sat_flag=0.
REQ-019 Changes on band_data, band_gain or band_mask after capture SHALL NOT affect the mix in progress.

Reset
REQ-020 Reset=1 at a clock edge SHALL force IDLE and set busy=0, out_valid=0, Dac=0, sat_flag=0, overrun=0, accumulator=0 and idx=0.
REQ-021 Reset asserted in ACCUM, SAT or OUT SHALL abort the mix, with no out_valid produced.
REQ-022 Reset SHALL take priority over sample_valid in the same cycle.

Structure
REQ-023 The FSM state encoding and the default values of Magnitud, Decimal, N_ADC, GAIN_FRAC and NUM_BANDS SHALL be kept in the shared equalizer package.
REQ-024 Saturation-and-truncation SHALL be a separate combinational sub-module, saturador_dac, parameterised by the accumulator width, N and N_ADC.

Verification
REQ-025 The bench SHALL cover these directed scenarios (NUM_BANDS=4 unless stated):
- All bands 16384 (1.0), gains 64, mask 1111 -> Dac=32, sat_flag=0, out_valid at cycle 6.
- band0 = -16384, gain 64, mask 0001 -> Dac=0xFF8 (-8).
- All bands 4194303, gains 128, mask 1111 -> Dac=2047 (0x7FF), sat_flag=1.
- Mask 0000 with any data -> Dac=0, out_valid at cycle 6, busy low at cycle 7.
- sample_valid at cycles 0 and 2 -> one out_valid, from the first capture's data; overrun=1 until Reset.
- Reset at cycle 3 of a mix -> no out_valid, Dac=0, busy=0; a new sample_valid at cycle 5 -> out_valid at cycle 11.
